// File: rtl/cam_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : cam_pattern_gen
// Purpose  : Synthetic OV7670-style RGB444 frame source (vsync/href/pixel byte)
//            that stands in for the camera. Optional CAM_PATTERN_SCROLL_EN
//            adds a per-frame horizontal scroll offset.
// Revision : 1.0 - initial release
// ============================================================================
module cam_pattern_gen #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP_LINES  = 2,
  parameter int V_FP_LINES  = 2
) (
  input  logic        CAM_pclk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int c_LINE_LEN = 2*H_ACTIVE + H_BLANK;
  localparam int c_VS_CYC   = VSYNC_LINES*c_LINE_LEN;
  localparam int c_BP_CYC   = V_BP_LINES*c_LINE_LEN;
  localparam int c_FP_CYC   = V_FP_LINES*c_LINE_LEN;
  localparam int c_CNT_W    = $clog2(c_VS_CYC + c_BP_CYC + c_FP_CYC + c_LINE_LEN + 1);
  localparam int c_XW       = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
  localparam int c_YW       = ($clog2(V_ACTIVE+1) > 7) ? $clog2(V_ACTIVE+1) : 7;
  localparam int c_BAR_W    = H_ACTIVE/8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VSYNC = 3'd1;
  localparam logic [2:0] S_VBP   = 3'd2;
  localparam logic [2:0] S_ACT   = 3'd3;
  localparam logic [2:0] S_HBL   = 3'd4;
  localparam logic [2:0] S_VFP   = 3'd5;

  logic [2:0]         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_XW-1:0]    r_x, w_x_eff;
  logic [c_YW-1:0]    r_y;
  logic               r_byte;
  logic [1:0]         r_mode;
  logic [11:0]        r_solid;
  logic [7:0]         r_rgb;
  logic [11:0]        w_rgb;
  logic [2:0]         w_bar;
  logic               w_last, w_latch;
  logic               w_vsync, w_href, w_done;
  logic [7:0]         w_px;

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_VSYNC: w_last = (r_cnt == c_CNT_W'(c_VS_CYC - 1));
      S_VBP:   w_last = (r_cnt == c_CNT_W'(c_BP_CYC - 1));
      S_ACT:   w_last = (r_cnt == c_CNT_W'(2*H_ACTIVE - 1));
      S_HBL:   w_last = (r_cnt == c_CNT_W'(H_BLANK - 1));
      S_VFP:   w_last = (r_cnt == c_CNT_W'(c_FP_CYC - 1));
      default: w_last = 1'b0;
    endcase
  end

  // Mode/colour are only sampled at a frame start so a frame never tears.
  assign w_latch = en && ((r_state == S_IDLE) || ((r_state == S_VFP) && w_last));

  always_ff @(posedge CAM_pclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)     w_state_nxt = S_VSYNC;
      S_VSYNC: if (w_last) w_state_nxt = S_VBP;
      S_VBP:   if (w_last) w_state_nxt = S_ACT;
      S_ACT:   if (w_last) w_state_nxt = S_HBL;
      S_HBL:   if (w_last) w_state_nxt = (r_y == c_YW'(V_ACTIVE - 1)) ? S_VFP : S_ACT;
      S_VFP:   if (w_last) w_state_nxt = en ? S_VSYNC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CAM_pclk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_byte  <= 1'b0;
      r_mode  <= 2'd0;
      r_solid <= 12'h000;
      r_rgb   <= 8'h00;
    end else begin
      r_cnt <= (w_last || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;
      if (w_latch) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
      if (r_state == S_VSYNC) r_y <= '0;
      if ((r_state == S_HBL) && w_last) r_y <= r_y + 1'b1;
      if (r_state == S_ACT) begin
        r_byte <= ~r_byte;
        if (r_byte) r_x <= w_last ? '0 : r_x + 1'b1;
        else        r_rgb <= w_rgb[7:0];
      end else begin
        r_byte <= 1'b0;
      end
    end
  end

`ifdef CAM_PATTERN_SCROLL_EN
  localparam int c_XW1 = c_XW + 1;
  logic [c_XW-1:0] r_offset;
  logic [c_XW:0]   w_sum;

  always_ff @(posedge CAM_pclk) begin
    if (reset)       r_offset <= '0;
    else if (w_done) r_offset <= (r_offset == c_XW'(H_ACTIVE - 1)) ? '0 : r_offset + 1'b1;
  end

  assign w_sum   = {1'b0, r_x} + {1'b0, r_offset};
  assign w_x_eff = (w_sum >= c_XW1'(H_ACTIVE)) ? c_XW'(w_sum - c_XW1'(H_ACTIVE))
                                                : w_sum[c_XW-1:0];
`else
  assign w_x_eff = r_x;
`endif

  // Pixel colour is evaluated on the byte1 cycle; byte2 replays its low byte.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (w_x_eff >= c_XW'(k*c_BAR_W)) w_bar = 3'(k);
    w_rgb = 12'h000;
    case (r_mode)
      2'd0: begin
        case (w_bar)
          3'd0:    w_rgb = 12'hFFF;
          3'd1:    w_rgb = 12'hFF0;
          3'd2:    w_rgb = 12'h0FF;
          3'd3:    w_rgb = 12'h0F0;
          3'd4:    w_rgb = 12'hF0F;
          3'd5:    w_rgb = 12'hF00;
          3'd6:    w_rgb = 12'h00F;
          default: w_rgb = 12'h000;
        endcase
      end
      2'd1:    w_rgb = {w_x_eff[7:4], r_y[6:3], w_x_eff[3:0]};
      2'd2:    w_rgb = r_solid;
      default: w_rgb = (w_x_eff[3] ^ r_y[3]) ? 12'hFFF : 12'h000;
    endcase
  end

  always_comb begin
    w_vsync = (r_state == S_VSYNC);
    w_href  = (r_state == S_ACT);
    w_done  = (r_state == S_VFP) && w_last;
    w_px    = 8'h00;
    if (r_state == S_ACT) w_px = r_byte ? r_rgb : {4'h0, w_rgb[11:8]};
  end

  always_ff @(posedge CAM_pclk) begin
    if (reset) begin
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= 8'h00;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      CAM_vsync   <= w_vsync;
      CAM_href    <= w_href;
      CAM_px_data <= w_px;
      frame_done  <= w_done;
      frame_cnt   <= frame_cnt + {7'd0, w_done};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_pattern_gen.sv
`default_nettype none
// Testbench for cam_pattern_gen: frame-position reference model feeding a
// scoreboard of expected output tuples, compared every cycle.
module tb_cam_pattern_gen;

  localparam int H_ACTIVE    = 160;
  localparam int V_ACTIVE    = 120;
  localparam int H_BLANK     = 16;
  localparam int VSYNC_LINES = 3;
  localparam int V_BP_LINES  = 2;
  localparam int V_FP_LINES  = 2;
  localparam int LINE_LEN    = 2*H_ACTIVE + H_BLANK;
  localparam int VS_END      = VSYNC_LINES*LINE_LEN;
  localparam int ACT_START   = VS_END + V_BP_LINES*LINE_LEN;
  localparam int ACT_END     = ACT_START + V_ACTIVE*LINE_LEN;
  localparam int FRAME       = ACT_END + V_FP_LINES*LINE_LEN;

  logic        CAM_pclk = 1'b0;
  logic        reset, en;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data, frame_cnt;

  cam_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BP_LINES(V_BP_LINES), .V_FP_LINES(V_FP_LINES)
  ) dut (
    .CAM_pclk(CAM_pclk), .reset(reset), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .CAM_vsync(CAM_vsync), .CAM_href(CAM_href), .CAM_px_data(CAM_px_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] px;
    logic       dn;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [11:0] m_solid = 12'h000;
  logic [7:0]  m_cnt = 8'd0;
  int          m_off = 0;

  function automatic logic [11:0] pix(int x, int y, logic [1:0] md, logic [11:0] sol, int off);
    int         xe;
    logic [7:0] xv, yv;
    logic [11:0] c;
    xe = (x + off) % H_ACTIVE;
    xv = 8'(xe);
    yv = 8'(y);
    c  = 12'h000;
    case (md)
      2'd0: begin
        case (xe / (H_ACTIVE/8))
          0: c = 12'hFFF;
          1: c = 12'hFF0;
          2: c = 12'h0FF;
          3: c = 12'h0F0;
          4: c = 12'hF0F;
          5: c = 12'hF00;
          6: c = 12'h00F;
          default: c = 12'h000;
        endcase
      end
      2'd1: c = {xv[7:4], yv[6:3], xv[3:0]};
      2'd2: c = sol;
      default: c = (xv[3] ^ yv[3]) ? 12'hFFF : 12'h000;
    endcase
    return c;
  endfunction

  function automatic obs_t expect_now();
    obs_t        o;
    int          q, ln, c;
    logic [11:0] rgb;
    o = '0;
    o.cnt = m_cnt;
    if (m_run) begin
      if (m_pos < VS_END) begin
        o.vs = 1'b1;
      end else if (m_pos >= ACT_START && m_pos < ACT_END) begin
        q  = m_pos - ACT_START;
        ln = q / LINE_LEN;
        c  = q % LINE_LEN;
        if (c < 2*H_ACTIVE) begin
          o.hr = 1'b1;
          rgb  = pix(c/2, ln, m_mode, m_solid, m_off);
          o.px = (c % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
        end
      end
      if (m_pos == FRAME-1) begin
        o.dn  = 1'b1;
        o.cnt = m_cnt + 8'd1;
      end
    end
    return o;
  endfunction

  // Reference model: m_pos is the frame cycle the DUT is in before each edge.
  always @(posedge CAM_pclk) begin
    obs_t e;
    e = reset ? '0 : expect_now();
    exp_q.push_back(e);
    if (reset) begin
      m_run <= 1'b0;
      m_cnt <= 8'd0;
      m_off <= 0;
    end else if (!m_run) begin
      if (en) begin
        m_run   <= 1'b1;
        m_pos   <= 0;
        m_mode  <= mode;
        m_solid <= solid_rgb;
      end
    end else if (m_pos == FRAME-1) begin
      m_cnt <= m_cnt + 8'd1;
`ifdef CAM_PATTERN_SCROLL_EN
      m_off <= (m_off + 1) % H_ACTIVE;
`endif
      if (en) begin
        m_pos   <= 0;
        m_mode  <= mode;
        m_solid <= solid_rgb;
      end else begin
        m_run <= 1'b0;
      end
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  always @(negedge CAM_pclk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {CAM_vsync, CAM_href, CAM_px_data, frame_done, frame_cnt};
      vectors++;
      assert (a === e) else begin
        miscompares++;
        $error("FAIL outputs t=%0t observed vs=%b hr=%b px=%h dn=%b cnt=%0d expected vs=%b hr=%b px=%h dn=%b cnt=%0d",
               $time, a.vs, a.hr, a.px, a.dn, a.cnt, e.vs, e.hr, e.px, e.dn, e.cnt);
      end
    end
  end

  task automatic wait_pos(input int target, input int limit);
    int n;
    n = 0;
    while (!(m_run && m_pos == target) && n < limit) begin
      @(negedge CAM_pclk);
      n++;
    end
    vectors++;
    assert (n < limit) else begin
      miscompares++;
      $error("FAIL wait_pos target=%0d observed=timeout expected=reached", target);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (m_run && n < limit) begin
      @(negedge CAM_pclk);
      n++;
    end
    vectors++;
    assert (n < limit) else begin
      miscompares++;
      $error("FAIL wait_idle observed=timeout expected=idle");
    end
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b1;
    mode      = 2'd3;
    solid_rgb = 12'h000;
    repeat (3) @(negedge CAM_pclk);
    reset = 1'b0;

    // Frame A: checkerboard through line 8, reset lands on a byte2 cycle.
    wait_pos(ACT_START + 8*LINE_LEN + 201, 10000);
    reset     = 1'b1;
    mode      = 2'd2;
    solid_rgb = 12'hABC;
    repeat (2) @(negedge CAM_pclk);
    reset = 1'b0;

    // Frame B: solid ABC; mode change mid-frame only applies to frame C.
    wait_pos(ACT_START + 30*LINE_LEN, 20000);
    mode      = 2'd0;
    solid_rgb = 12'h123;

    // Frame C: colour bars; mode change ignored, en dropped on line 50.
    wait_pos(ACT_START + 20*LINE_LEN, 50000);
    mode = 2'd1;
    wait_pos(ACT_START + 50*LINE_LEN + 100, 20000);
    en = 1'b0;
    wait_idle(50000);
    repeat (4) @(negedge CAM_pclk);

    // Frame D: gradient, then reset during byte2 of line 4.
    en = 1'b1;
    wait_pos(ACT_START + 4*LINE_LEN + 11, 10000);
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge CAM_pclk);
    reset = 1'b0;
    repeat (3) @(negedge CAM_pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
